// File: rtl/axis_rr_packet_arbiter_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
// Latency: n/a (package only).
// Backpressure: n/a.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Width of a grant index; never below 1 bit so a 1-input build still has a legal vector.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_rr_packet_arbiter_if.sv
// AXI4-Stream bundle with LANES parallel lanes (LANES=1 for a plain stream).
// Latency: n/a (wires only).
// Backpressure: tready flows from slave-side consumer back to the master-side producer.
// Ports: tdata[LANES*WIDTH], tvalid/tlast/tready[LANES], tid[ID_WIDTH].
interface axis_rr_packet_arbiter_if #(
    parameter int LANES    = 1,
    parameter int WIDTH    = 8,
    parameter int ID_WIDTH = 1
);
    logic [LANES*WIDTH-1:0] tdata;
    logic [LANES-1:0]       tvalid;
    logic [LANES-1:0]       tlast;
    logic [LANES-1:0]       tready;
    logic [ID_WIDTH-1:0]    tid;

    // Producer side: drives payload, receives ready.
    modport master (
        output tdata, tvalid, tlast, tid,
        input  tready
    );

    // Consumer side: receives payload, drives ready.
    modport slave (
        input  tdata, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/axis_rr_packet_arbiter_picker.sv
// rr_priority_picker: first asserted request scanning upward from last_grant+1 (mod N).
// Latency: combinational.
// Backpressure: none.
// Ports: req[N], last_grant -> found, index.
module rr_priority_picker
    import axis_arb_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int ID_WIDTH   = id_width(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [ID_WIDTH-1:0]   last_grant,
    output logic                  found,
    output logic [ID_WIDTH-1:0]   index
);

    always_comb begin
        int cand;
        found = 1'b0;
        index = '0;
        cand  = 0;
        // Offset 1..N: the previous owner is checked last, so it has lowest priority.
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            cand = (int'(last_grant) + k) % NUM_INPUTS;
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand[ID_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// N-to-1 AXI4-Stream arbiter, round-robin at packet granularity; reports owner and packet beat counts.
// Latency: one arbitration cycle in IDLE, then zero-latency combinational data path while BUSY.
// Backpressure: m_axis.tready is steered only to the owning input; all other inputs see tready=0.
// Ports: clk, resetn (sync, active-low), s_axis (slave, NUM_INPUTS lanes), m_axis (master, 1 lane),
//        busy (grant held), last_pkt_beats (saturating beat count of last completed packet).
module axis_rr_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 4,
    parameter int ID_WIDTH   = id_width(NUM_INPUTS),
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    axis_rr_packet_arbiter_if.slave  s_axis,
    axis_rr_packet_arbiter_if.master m_axis,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    last_pkt_beats
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    arb_state_t           state, state_nxt;
    logic [ID_WIDTH-1:0]  grant;
    logic [ID_WIDTH-1:0]  last_grant;
    logic [CNT_WIDTH-1:0] beat_cnt;

    logic                 pick_found;
    logic [ID_WIDTH-1:0]  pick_idx;
    logic                 xfer;
    logic                 xfer_last;

    rr_priority_picker #(
        .NUM_INPUTS (NUM_INPUTS),
        .ID_WIDTH   (ID_WIDTH)
    ) u_picker (
        .req        (s_axis.tvalid),
        .last_grant (last_grant),
        .found      (pick_found),
        .index      (pick_idx)
    );

    always_comb begin
        state_nxt     = state;
        s_axis.tready = '0;
        m_axis.tvalid = 1'b0;
        m_axis.tlast  = 1'b0;
        m_axis.tdata  = s_axis.tdata[int'(grant)*WIDTH +: WIDTH];
        m_axis.tid    = grant;
        xfer          = 1'b0;
        xfer_last     = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                m_axis.tvalid        = s_axis.tvalid[grant];
                m_axis.tlast         = s_axis.tlast[grant];
                s_axis.tready[grant] = m_axis.tready;
                xfer                 = s_axis.tvalid[grant] && m_axis.tready;
                xfer_last            = xfer && s_axis.tlast[grant];
                if (xfer_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            grant          <= '0;
            last_grant     <= ID_WIDTH'(NUM_INPUTS - 1);
            beat_cnt       <= '0;
            last_pkt_beats <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_found) begin
                grant <= pick_idx;
            end
            if (xfer_last) begin
                // beat_cnt holds beats before this one; add the tlast beat, saturating.
                last_pkt_beats <= (beat_cnt == CNT_MAX) ? CNT_MAX : beat_cnt + 1'b1;
                beat_cnt       <= '0;
                last_grant     <= grant;
            end else if (xfer && beat_cnt != CNT_MAX) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed bench for axis_rr_packet_arbiter: per-cycle vector table plus a long saturating packet.
module tb_axis_rr_packet_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          busy;
    logic [CW-1:0] last_pkt_beats;

    axis_rr_packet_arbiter_if #(.LANES(N), .WIDTH(W), .ID_WIDTH(IDW)) s_if ();
    axis_rr_packet_arbiter_if #(.LANES(1), .WIDTH(W), .ID_WIDTH(IDW)) m_if ();

    axis_rr_packet_arbiter #(
        .WIDTH      (W),
        .NUM_INPUTS (N),
        .ID_WIDTH   (IDW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .s_axis         (s_if.slave),
        .m_axis         (m_if.master),
        .busy           (busy),
        .last_pkt_beats (last_pkt_beats)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic [N-1:0]  vld;
        logic [N-1:0]  lst;
        logic          rdy;
        logic          e_busy;
        logic [N-1:0]  e_srdy;
        logic          e_mvld;
        logic          e_mlst;
        logic [IDW-1:0] e_tid;
        logic [CW-1:0] e_lpb;
    } vec_t;

    vec_t vq[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s (vec %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive at negedge, compare combinational view #1 later, before the next rising edge.
    task automatic apply(input vec_t v, input int idx);
        logic [W-1:0] exp_dat;
        @(negedge clk);
        resetn         = v.rst_n;
        s_if.tvalid    = v.vld;
        s_if.tlast     = v.lst;
        m_if.tready[0] = v.rdy;
        #1;
        chk("busy",   idx, 32'(busy),           32'(v.e_busy));
        chk("s_rdy",  idx, 32'(s_if.tready),    32'(v.e_srdy));
        chk("m_vld",  idx, 32'(m_if.tvalid[0]), 32'(v.e_mvld));
        chk("lpb",    idx, 32'(last_pkt_beats), 32'(v.e_lpb));
        if (v.e_mvld) begin
            exp_dat = 8'hA0 + W'(v.e_tid);
            chk("m_lst", idx, 32'(m_if.tlast[0]), 32'(v.e_mlst));
            chk("m_tid", idx, 32'(m_if.tid),      32'(v.e_tid));
            chk("m_dat", idx, 32'(m_if.tdata),    32'(exp_dat));
        end
    endtask

    task automatic add(input logic r, input logic [3:0] vld, input logic [3:0] lst, input logic rdy,
                       input logic eb, input logic [3:0] es, input logic ev, input logic el,
                       input logic [1:0] et, input logic [15:0] ep);
        vec_t v;
        v.rst_n = r; v.vld = vld; v.lst = lst; v.rdy = rdy;
        v.e_busy = eb; v.e_srdy = es; v.e_mvld = ev; v.e_mlst = el; v.e_tid = et; v.e_lpb = ep;
        vq.push_back(v);
    endtask

    initial begin
        int misses;
        int waited;
        resetn      = 1'b0;
        s_if.tdata  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        s_if.tvalid = '0;
        s_if.tlast  = '0;
        s_if.tid    = '0;
        m_if.tready = '0;
        repeat (2) @(posedge clk);

        //   rst vld     lst     rdy | busy srdy    mvld mlst tid lpb
        // Reset hold, idle inputs.
        add(0, 4'b0000, 4'b0000, 1,   0, 4'b0000, 0, 0, 0, 0);
        add(1, 4'b0000, 4'b0000, 1,   0, 4'b0000, 0, 0, 0, 0);
        // Input 2 alone, 3 beats: one arbitration cycle, then 3 beats, busy drops after tlast.
        add(1, 4'b0100, 4'b0000, 1,   0, 4'b0000, 0, 0, 0, 0);
        add(1, 4'b0100, 4'b0000, 1,   1, 4'b0100, 1, 0, 2, 0);
        add(1, 4'b0100, 4'b0000, 1,   1, 4'b0100, 1, 0, 2, 0);
        add(1, 4'b0100, 4'b0100, 1,   1, 4'b0100, 1, 1, 2, 0);
        add(1, 4'b0000, 4'b0000, 1,   0, 4'b0000, 0, 0, 0, 3);
        // Reset, then all inputs send 1-beat packets: grants 0,1,2,3,0,1 every 2 cycles.
        add(0, 4'b0000, 4'b0000, 1,   0, 4'b0000, 0, 0, 0, 3);
        add(1, 4'b1111, 4'b1111, 1,   0, 4'b0000, 0, 0, 0, 0);
        add(1, 4'b1111, 4'b1111, 1,   1, 4'b0001, 1, 1, 0, 0);
        add(1, 4'b1111, 4'b1111, 1,   0, 4'b0000, 0, 0, 0, 1);
        add(1, 4'b1111, 4'b1111, 1,   1, 4'b0010, 1, 1, 1, 1);
        add(1, 4'b1111, 4'b1111, 1,   0, 4'b0000, 0, 0, 0, 1);
        add(1, 4'b1111, 4'b1111, 1,   1, 4'b0100, 1, 1, 2, 1);
        add(1, 4'b1111, 4'b1111, 1,   0, 4'b0000, 0, 0, 0, 1);
        add(1, 4'b1111, 4'b1111, 1,   1, 4'b1000, 1, 1, 3, 1);
        add(1, 4'b1111, 4'b1111, 1,   0, 4'b0000, 0, 0, 0, 1);
        add(1, 4'b1111, 4'b1111, 1,   1, 4'b0001, 1, 1, 0, 1);
        add(1, 4'b1111, 4'b1111, 1,   0, 4'b0000, 0, 0, 0, 1);
        add(1, 4'b1111, 4'b1111, 1,   1, 4'b0010, 1, 1, 1, 1);
        // Input 1 re-granted; ready stalls and valid drop mid-packet, others stay blocked.
        add(1, 4'b0010, 4'b0000, 1,   0, 4'b0000, 0, 0, 0, 1);
        add(1, 4'b1111, 4'b0000, 1,   1, 4'b0010, 1, 0, 1, 1);
        add(1, 4'b1111, 4'b0000, 0,   1, 4'b0000, 1, 0, 1, 1);
        add(1, 4'b1101, 4'b0000, 0,   1, 4'b0000, 0, 0, 0, 1);
        add(1, 4'b1101, 4'b0000, 1,   1, 4'b0010, 0, 0, 0, 1);
        add(1, 4'b1111, 4'b0010, 1,   1, 4'b0010, 1, 1, 1, 1);
        add(1, 4'b0000, 4'b0000, 1,   0, 4'b0000, 0, 0, 0, 2);
        // Input 3 packet interrupted by reset on beat 2; afterwards input 0 beats input 3.
        add(1, 4'b1000, 4'b0000, 1,   0, 4'b0000, 0, 0, 0, 2);
        add(1, 4'b1000, 4'b0000, 1,   1, 4'b1000, 1, 0, 3, 2);
        add(0, 4'b1000, 4'b0000, 1,   1, 4'b1000, 1, 0, 3, 2);
        add(1, 4'b1001, 4'b0000, 1,   0, 4'b0000, 0, 0, 0, 0);
        add(1, 4'b1001, 4'b0001, 1,   1, 4'b0001, 1, 1, 0, 0);
        add(1, 4'b0000, 4'b0000, 1,   0, 4'b0000, 0, 0, 0, 1);

        foreach (vq[i]) apply(vq[i], i);

        // 70000-beat packet on input 0: beat count must saturate at 65535.
        @(negedge clk);
        s_if.tvalid    = 4'b0001;
        s_if.tlast     = 4'b0000;
        m_if.tready[0] = 1'b1;
        waited = 0;
        while (!busy && waited < 5) begin
            @(negedge clk);
            waited++;
        end
        chk("long_grant", 0, 32'(busy), 32'd1);
        misses = 0;
        for (int b = 1; b <= 70000; b++) begin
            s_if.tlast = (b == 70000) ? 4'b0001 : 4'b0000;
            #1;
            if (!(m_if.tvalid[0] && s_if.tready[0])) misses++;
            @(negedge clk);
        end
        s_if.tvalid = '0;
        s_if.tlast  = '0;
        #1;
        chk("long_beats", 0, 32'(misses),         32'd0);
        chk("long_busy",  0, 32'(busy),           32'd0);
        chk("long_lpb",   0, 32'(last_pkt_beats), 32'd65535);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
